// File: rtl/imm_instr_encoder.sv
// Instruction word encoder with immediate range check.
// Streams legal words into instruction memory through an address counter.
module imm_instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [9:0]        in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err_imm,
    output logic              err_full,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BASE_ADDR + DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FULL, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic              done_q, done_d;
    logic              err_imm_q, err_imm_d;
    logic              err_full_q, err_full_d;

    logic [9:0]  imm_field;
    logic        illegal;
    logic [31:0] word;
    logic        xfer;

    // Select the immediate field by opcode format and flag out-of-range values
    always_comb begin
        imm_field = 10'd0;
        illegal   = 1'b0;
        unique case (in_opcode)
            5'b11000: imm_field = in_imm;
            5'b11001, 5'b10001, 5'b10011,
            5'b10010, 5'b11101: begin
                imm_field = {5'd0, in_imm[4:0]};
                illegal   = |in_imm[9:5];
            end
            default: imm_field = 10'd0;
        endcase
    end

    assign word = {in_opcode, in_rd, in_rs, 7'd0, imm_field};
    assign xfer = in_valid & in_ready_q;

    // Load sequencer: next state, write pointer and registered outputs
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        word_count_d = word_count_q;
        err_full_d   = err_full_q;
        mem_we_d     = 1'b0;
        done_d       = 1'b0;
        err_imm_d    = 1'b0;
        unique case (state_q)
            IDLE, FULL: begin
                if (start) begin
                    state_d      = RUN;
                    ptr_d        = BASE;
                    mem_addr_d   = BASE;
                    word_count_d = '0;
                    err_full_d   = 1'b0;
                end else if (state_q == FULL && in_valid) begin
                    err_full_d = 1'b1;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (illegal) begin
                        err_imm_d = 1'b1;
                    end else begin
                        mem_we_d     = 1'b1;
                        mem_addr_d   = ptr_q;
                        mem_wdata_d  = word;
                        word_count_d = word_count_q + 1'b1;
                        if (ptr_q != LAST) ptr_d = ptr_q + 1'b1;
                    end
                    if (in_last) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (!illegal && ptr_q == LAST) begin
                        state_d = FULL;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == RUN);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= BASE;
            mem_addr_q   <= BASE;
            mem_wdata_q  <= '0;
            word_count_q <= '0;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            done_q       <= 1'b0;
            err_imm_q    <= 1'b0;
            err_full_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            word_count_q <= word_count_d;
            in_ready_q   <= in_ready_d;
            mem_we_q     <= mem_we_d;
            done_q       <= done_d;
            err_imm_q    <= err_imm_d;
            err_full_q   <= err_full_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign done       = done_q;
    assign err_imm    = err_imm_q;
    assign err_full   = err_full_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Scoreboard bench for imm_instr_encoder.
// A small memory depth makes the FULL path reachable.
module tb_imm_instr_encoder;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n, start, in_valid, in_ready, in_last;
    logic [4:0]    in_opcode, in_rd, in_rs;
    logic [9:0]    in_imm;
    logic          mem_we, done, err_imm, err_full;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   word_count;

    typedef struct {
        logic        we;
        logic        err;
        logic        dn;
        logic [9:0]  addr;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    imm_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs),
        .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .done(done), .err_imm(err_imm),
        .err_full(err_full), .word_count(word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every output event must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && (mem_we || err_imm || done)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event we=%b err=%b done=%b addr=%h",
                         mem_we, err_imm, done, mem_addr);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("mon_we", 32'(mem_we), 32'(e.we));
                chk("mon_err_imm", 32'(err_imm), 32'(e.err));
                chk("mon_done", 32'(done), 32'(e.dn));
                if (e.we) begin
                    chk("mon_addr", 32'(mem_addr), 32'(e.addr));
                    chk("mon_wdata", mem_wdata, e.data);
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one word; returns at the negedge where its result is visible
    task automatic xfer(input logic [4:0] op, input logic [4:0] rd,
                        input logic [4:0] rs, input logic [9:0] imm,
                        input logic last, input logic exp_err,
                        input logic [9:0] exp_addr, input logic [31:0] exp_data);
        int n;
        ev_t e;
        in_opcode = op;
        in_rd     = rd;
        in_rs     = rs;
        in_imm    = imm;
        in_last   = last;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout in_ready got 0 want 1");
        end else begin
            @(posedge clk);
            e.we   = !exp_err;
            e.err  = exp_err;
            e.dn   = last;
            e.addr = exp_addr;
            e.data = exp_data;
            exp_q.push_back(e);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_opcode = '0;
        in_rd = '0;
        in_rs = '0;
        in_imm = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_word_count", 32'(word_count), 0);
        chk("rst_flags", {29'd0, done, err_imm, err_full}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 0);

        // Single 10-bit immediate word marked last
        pulse_start();
        chk("run_in_ready", 32'(in_ready), 1);
        xfer(5'b11000, 5'd3, 5'd5, 10'h3FF, 1'b1, 1'b0, 10'd0, 32'hC0CA03FF);
        in_valid = 1'b0;
        chk("done_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        chk("idle_after_done", 32'(in_ready), 0);
        chk("wc_after_one", 32'(word_count), 1);

        // 5-bit format, out-of-range drop, forced-zero immediate
        pulse_start();
        xfer(5'b11001, 5'd1, 5'd2, 10'd17, 1'b0, 1'b0, 10'd0, 32'hC8440011);
        xfer(5'b10001, 5'd0, 5'd0, 10'd32, 1'b0, 1'b1, 10'd0, 32'h0);
        in_valid = 1'b0;
        chk("wc_after_drop", 32'(word_count), 1);
        @(negedge clk);
        xfer(5'b00000, 5'd7, 5'd7, 10'h155, 1'b0, 1'b0, 10'd1, 32'h01CE0000);
        xfer(5'b10011, 5'd2, 5'd4, 10'h01F, 1'b1, 1'b0, 10'd2, 32'h9888001F);
        in_valid = 1'b0;
        chk("wc_after_three", 32'(word_count), 3);
        @(negedge clk);

        // Back-to-back fill to FULL, then overflow attempt
        pulse_start();
        xfer(5'b10010, 5'd1, 5'd1, 10'd5, 1'b0, 1'b0, 10'd0, 32'h90420005);
        xfer(5'b11101, 5'd31, 5'd31, 10'h01F, 1'b0, 1'b0, 10'd1, 32'hEFFE001F);
        xfer(5'b00001, 5'd0, 5'd0, 10'h3FF, 1'b0, 1'b0, 10'd2, 32'h08000000);
        xfer(5'b11000, 5'd0, 5'd0, 10'h200, 1'b0, 1'b0, 10'd3, 32'hC0000200);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_wc", 32'(word_count), 4);
        chk("full_no_err", 32'(err_full), 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("err_full_set", 32'(err_full), 1);
        @(negedge clk);
        chk("err_full_sticky", 32'(err_full), 1);
        pulse_start();
        chk("err_full_clear", 32'(err_full), 0);
        chk("restart_wc", 32'(word_count), 0);
        chk("restart_ready", 32'(in_ready), 1);

        // Gapped stream, addresses must stay contiguous
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        xfer(5'b00010, 5'd1, 5'd1, 10'h0AA, 1'b0, 1'b0, 10'd0, 32'h10420000);
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        xfer(5'b00010, 5'd2, 5'd2, 10'h0AA, 1'b0, 1'b0, 10'd1, 32'h10840000);
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        xfer(5'b00010, 5'd3, 5'd3, 10'h0AA, 1'b1, 1'b0, 10'd2, 32'h10C60000);
        in_valid = 1'b0;
        @(negedge clk);

        // Last word dropped still finishes the load
        pulse_start();
        xfer(5'b10001, 5'd0, 5'd0, 10'h020, 1'b1, 1'b1, 10'd0, 32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("drop_last_idle", 32'(in_ready), 0);

        // Reset right after a transfer kills the pending write
        pulse_start();
        in_opcode = 5'b11000;
        in_imm = 10'd1;
        in_last = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_mid_we", 32'(mem_we), 0);
        chk("rst_mid_addr", 32'(mem_addr), 0);
        chk("rst_mid_wc", 32'(word_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(in_ready), 0);

        // start with in_valid in IDLE: no transfer
        start = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_start_valid_wc", 32'(word_count), 0);
        chk("idle_start_valid_run", 32'(in_ready), 1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
